// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and a word-addressed data memory; sub-word stores use read-modify-write.
// Optional feature: define DMEM_LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing alignment.
module dmem_lsu #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned MEM_RD_LAT = 1,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);
    localparam int unsigned CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
    localparam logic [1:0]  SZ_B  = 2'b00;
    localparam logic [1:0]  SZ_H  = 2'b01;
    localparam logic [1:0]  SZ_W  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        sh_q, sh_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic              trap;
    logic [1:0]        off;
    logic [31:0]       rd_shifted, lane_mask, load_ext, store_merged;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // Bit position of the addressed lane(s) inside the 32-bit word.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] ofs);
        logic [2:0] nbytes;
        logic [1:0] lane;
        nbytes = (size == SZ_B) ? 3'd1 : (size == SZ_H) ? 3'd2 : 3'd4;
        lane   = BIG_ENDIAN ? 2'(3'd4 - nbytes - {1'b0, ofs}) : ofs;
        return {lane, 3'b000};
    endfunction

    // Request decode: error detection and effective byte offset.
    always_comb begin
        off  = req_addr[1:0];
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        trap = (req_size == 2'b11)
             || (req_size == SZ_H && req_addr[0])
             || (req_size == SZ_W && req_addr[1:0] != 2'b00);
`else
        trap = (req_size == 2'b11);
        if (req_size == SZ_H) begin
            off = {req_addr[1], 1'b0};
        end else if (req_size == SZ_W) begin
            off = 2'b00;
        end
`endif
    end

    // Load extraction/extension and sub-word store merge from the returned word.
    always_comb begin
        rd_shifted = mem_rdata >> sh_q;
        lane_mask  = (size_q == SZ_B) ? 32'h0000_00FF :
                     (size_q == SZ_H) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        case (size_q)
            SZ_B:    load_ext = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
            SZ_H:    load_ext = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_ext = rd_shifted;
        endcase
        store_merged = (mem_rdata & ~(lane_mask << sh_q)) | ((wdata_q & lane_mask) << sh_q);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        sh_d        = sh_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    wdata_d  = req_wdata;
                    sh_d     = lane_shift(req_size, off);
                    if (trap) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        mem_addr_d = req_addr[ADDR_W+1:2];
                        if (req_write && req_size == SZ_W) begin
                            state_d     = S_WR_ISSUE;
                            mem_write_d = 1'b1;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d    = S_RD_ISSUE;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            S_RD_ISSUE: begin
                state_d = S_RD_WAIT;
                cnt_d   = '0;
            end
            S_RD_WAIT: begin
                if (cnt_q == CNT_W'(MEM_RD_LAT - 1)) begin
                    if (write_q) begin
                        state_d     = S_WR_ISSUE;
                        mem_write_d = 1'b1;
                        mem_wdata_d = store_merged;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = load_ext;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR_ISSUE: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            wdata_q     <= 32'h0;
            sh_q        <= 5'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            wdata_q     <= wdata_d;
            sh_q        <= sh_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: byte-level reference memory model, directed cases then random traffic.
module tb_dmem_lsu;
    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned MEM_RD_LAT = 1;
    localparam bit          BIG_ENDIAN = 1'b0;

    logic              clk, rst_n;
    logic              req_valid, req_ready, req_write, req_signed;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              mem_read, mem_write;

    dmem_lsu #(.ADDR_W(ADDR_W), .MEM_RD_LAT(MEM_RD_LAT), .BIG_ENDIAN(BIG_ENDIAN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0]       rdata;
        logic              err;
        int                lat;
        int                n_rd;
        int                n_wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [16];
    logic [31:0] dmem    [16];
    bit          mem_loaded = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Data memory with one-cycle synchronous read; preloaded from the reference image.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) dmem[i] <= ref_mem[i];
            mem_loaded <= 1'b1;
        end else begin
            if (mem_write) dmem[mem_addr[3:0]] <= mem_wdata;
            if (mem_read)  mem_rdata <= dmem[mem_addr[3:0]];
        end
    end

    // Reference: memory viewed as bytes at byte offsets 0..3 within each word.
    function automatic void model(input logic wr, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output exp_t e, output logic [31:0] new_word);
        int          nb, ofs, lane;
        logic [7:0]  b [4];
        logic [31:0] word, val;
        e = '{rdata: 32'h0, err: 1'b0, lat: 1, n_rd: 0, n_wr: 0,
              addr: ADDR_W'(addr >> 2), wdata: 32'h0};
        word     = ref_mem[addr[5:2]];
        new_word = word;
        if (size == 2'b11) begin
            e.err = 1'b1;
            return;
        end
        nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        ofs = int'(addr[1:0]);
        if (ofs % nb != 0) begin
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
            e.err = 1'b1;
            return;
`else
            ofs = ofs - (ofs % nb);
`endif
        end
        for (int k = 0; k < 4; k++) b[k] = BIG_ENDIAN ? word[8*(3-k) +: 8] : word[8*k +: 8];
        if (!wr) begin
            val = 32'h0;
            for (int i = 0; i < nb; i++) begin
                lane = BIG_ENDIAN ? ofs + nb - 1 - i : ofs + i;
                val  = val | (32'(b[lane]) << (8*i));
            end
            if (sgn && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
            e.rdata = val;
            e.n_rd  = 1;
            e.lat   = 2 + MEM_RD_LAT;
        end else begin
            for (int i = 0; i < nb; i++) begin
                lane    = BIG_ENDIAN ? ofs + nb - 1 - i : ofs + i;
                b[lane] = wdata[8*i +: 8];
            end
            for (int k = 0; k < 4; k++) begin
                if (BIG_ENDIAN) new_word[8*(3-k) +: 8] = b[k];
                else            new_word[8*k +: 8]     = b[k];
            end
            e.wdata = new_word;
            e.n_wr  = 1;
            e.n_rd  = (nb < 4) ? 1 : 0;
            e.lat   = (nb < 4) ? 3 + MEM_RD_LAT : 2;
        end
    endfunction

    // Monitor: samples just after each rising edge and checks against the scoreboard.
    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    always @(posedge clk) begin
        bit   acc;
        exp_t e;
        int   a;
        acc = req_valid && req_ready && rst_n;
        #1;
        cyc++;
        if (acc) begin
            acc_q.push_back(cyc);
            rd_cnt = 0;
            wr_cnt = 0;
        end
        if (rst_n) begin
            if (mem_read || mem_write) begin
                if (exp_q.size() == 0) begin
                    chk("stray_strobe", {30'h0, mem_read, mem_write}, 32'h0);
                end else begin
                    chk("strobe_exclusive", 32'(mem_read && mem_write), 32'h0);
                    chk("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                    if (mem_read) rd_cnt++;
                    if (mem_write) begin
                        wr_cnt++;
                        chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                    end
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    chk("stray_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("latency", 32'(cyc - a + 1), 32'(e.lat));
                    chk("n_reads", 32'(rd_cnt), 32'(e.n_rd));
                    chk("n_writes", 32'(wr_cnt), 32'(e.n_wr));
                    chk("ready_in_resp", 32'(req_ready), 32'h0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
        chk({tag, "_rsp_rdata"}, rsp_rdata,      32'h0);
        chk({tag, "_mem_read"},  32'(mem_read),  32'h0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'h0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'h0);
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input bit commit);
        exp_t        e;
        logic [31:0] nw;
        int          t;
        model(wr, sz, sgn, addr, wd, e, nw);
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'h1);
        exp_q.push_back(e);
        if (commit && wr && !e.err) ref_mem[addr[5:2]] = nw;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        acc_q.delete();
    endtask

    initial begin
        logic [1:0] sz;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[5] = 32'h8899_AABB;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h17, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 1'b1);
        issue(1'b1, 2'b00, 1'b0, 32'h15, 32'h1234_5677, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1);
        issue(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEAD_BEEF, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h16, 32'h0, 1'b1);
        issue(1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 1'b1);
        issue(1'b1, 2'b11, 1'b0, 32'h14, 32'h5555_5555, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 1'b1);
        issue(1'b1, 2'b01, 1'b0, 32'h1A, 32'hCAFE_F00D, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 1'b1);
        wait_idle();

        // Abort an SH while it waits for read data; the store must never land.
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_ABCD, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("midop_reset");
        end
        rst_n = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1);
        wait_idle();

        for (int n = 0; n < 200; n++) begin
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            issue(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 63)), $urandom, 1'b1);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
